// File: rtl/load_store_unit_pkg.sv
// Shared RV32 definitions for the load/store unit.
// Width/sign codes and the LSU state encoding.
package rv32_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory req/ack bus between the LSU and memory.
// master = LSU side, slave = memory side.
interface load_store_unit_if;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_be,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_be,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: legality, byte enables,
// store replication and load extract/extend.
module lsu_align
  import rv32_pkg::*;
(
  input  logic [2:0]  i_f3,
  input  logic        i_store,
  input  logic [1:0]  i_alo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic        o_ok,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic        w_ill;
  logic        w_sx;
  logic [31:0] w_sh;

  assign w_sh = i_rdata >> {i_alo, 3'b000};
  assign w_sx = ~i_f3[2];

  // Stores allow only B/H/W; loads reject 011/110/111.
  always_comb begin
    if (i_store) begin
      w_ill = i_f3[2] | (i_f3[1:0] == 2'b11);
    end else begin
      w_ill = (i_f3 == 3'b011) | (i_f3[2:1] == 2'b11);
    end
  end

  // Width decode drives lanes, replication and extension.
  always_comb begin
    o_ok    = 1'b0;
    o_be    = 4'b0000;
    o_wdata = i_wdata;
    o_ldata = i_rdata;
    unique case (1'b1)
      (!w_ill && i_f3[1:0] == 2'b00): begin
        o_ok    = 1'b1;
        o_be    = 4'b0001 << i_alo;
        o_wdata = {4{i_wdata[7:0]}};
        o_ldata = {{24{w_sx & w_sh[7]}}, w_sh[7:0]};
      end
      (!w_ill && i_f3[1:0] == 2'b01): begin
        o_ok    = ~i_alo[0];
        o_be    = 4'b0011 << i_alo;
        o_wdata = {2{i_wdata[15:0]}};
        o_ldata = {{16{w_sx & w_sh[15]}}, w_sh[15:0]};
      end
      (!w_ill && i_f3[1:0] == 2'b10): begin
        o_ok    = (i_alo == 2'b00);
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_ldata = i_rdata;
      end
      default: begin
        o_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: captures an access, runs the
// req/ack bus with timeout, returns load data.
module load_store_unit
  import rv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      is_store,
  input  logic [2:0]                funct3,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  load_store_unit_if.master         bus,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [31:0]               rdata
);

  localparam logic [31:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  lsu_state_e  r_state;
  logic [2:0]  r_f3;
  logic        r_store;
  logic [1:0]  r_alo;
  logic [31:0] r_cnt;

  logic [2:0]  w_f3;
  logic        w_store;
  logic [1:0]  w_alo;
  logic        w_ok;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;

  // Decode live inputs in IDLE, captured ones after.
  assign w_f3    = (r_state == IDLE) ? funct3 : r_f3;
  assign w_store = (r_state == IDLE) ? is_store : r_store;
  assign w_alo   = (r_state == IDLE) ? addr[1:0] : r_alo;

  assign busy = (r_state != IDLE);

  lsu_align u_align (
    .i_f3    (w_f3),
    .i_store (w_store),
    .i_alo   (w_alo),
    .i_wdata (wdata),
    .i_rdata (bus.mem_rdata),
    .o_ok    (w_ok),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_ldata (w_ldata)
  );

  // Access FSM with registered bus and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_f3          <= 3'b000;
      r_store       <= 1'b0;
      r_alo         <= 2'b00;
      r_cnt         <= 32'd0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= 4'b0000;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 32'd0;
      done          <= 1'b0;
      err           <= 1'b0;
      rdata         <= 32'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_f3    <= funct3;
            r_store <= is_store;
            r_alo   <= addr[1:0];
            r_cnt   <= 32'd0;
            if (w_ok) begin
              r_state       <= REQ;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= is_store;
              bus.mem_be    <= w_be;
              bus.mem_addr  <= {addr[31:2], 2'b00};
              bus.mem_wdata <= w_wdata;
            end else begin
              r_state <= RESP;
              done    <= 1'b1;
              err     <= 1'b1;
              rdata   <= 32'd0;
            end
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            r_state     <= RESP;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            done        <= 1'b1;
            if (!r_store) begin
              rdata <= w_ldata;
            end
          end else if (TO_EN && r_cnt == TO_LAST) begin
            r_state     <= RESP;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            done        <= 1'b1;
            err         <= 1'b1;
            rdata       <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with
// a reference model and a req/ack memory responder.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  int n_tests;
  int n_fail;
  logic [31:0] model_rdata;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .is_store (is_store),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rdata    (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: byte count per code, alignment, lanes, extension.
  function automatic void model(
    input  bit          st,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [31:0] rd,
    output bit          ok,
    output logic [3:0]  be,
    output logic [31:0] mw,
    output logic [31:0] ld
  );
    int n;
    int off;
    longint mask;
    longint field;
    off = int'(a % 4);
    case (f3)
      3'd0:    n = 1;
      3'd1:    n = 2;
      3'd2:    n = 4;
      3'd4:    n = st ? 0 : 1;
      3'd5:    n = st ? 0 : 2;
      default: n = 0;
    endcase
    ok = (n != 0) && (off % (n == 0 ? 1 : n) == 0);
    be = 4'(((1 << n) - 1) << off);
    if (n == 1) mw = 32'(longint'(wd % 256) * 32'h01010101);
    else if (n == 2) mw = 32'(longint'(wd % 65536) * 32'h00010001);
    else mw = wd;
    mask = (n == 4) ? 64'hFFFFFFFF : ((64'd1 << (8 * n)) - 1);
    field = (longint'(rd) >> (8 * off)) & mask;
    if (f3 < 3'd2 && field > (mask >> 1)) field = field | (64'hFFFFFFFF & ~mask);
    ld = 32'(field);
  endfunction

  task automatic run_access(
    input  logic        st,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [31:0] rd,
    input  int          ack_after,
    input  bit          idle_ack,
    output int          req_cnt,
    output logic        we,
    output logic [3:0]  be,
    output logic [31:0] maddr,
    output logic [31:0] mwd,
    output int          done_cyc,
    output logic        derr,
    output logic [31:0] drd,
    output logic        pulse_ok
  );
    req_cnt = 0; done_cyc = -1; we = 0; be = 0;
    maddr = 0; mwd = 0; derr = 0; drd = 0; pulse_ok = 0;
    @(posedge clk); #1;
    start = 1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    bus.mem_ack = idle_ack; bus.mem_rdata = $urandom;
    @(posedge clk); #1;
    start = 0; bus.mem_ack = 0;
    addr = $urandom; wdata = $urandom;
    funct3 = 3'($urandom); is_store = 1'($urandom);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        done_cyc = c; derr = err; drd = rdata;
        break;
      end
      if (bus.mem_req) begin
        if (req_cnt == 0) begin
          we = bus.mem_we; be = bus.mem_be;
          maddr = bus.mem_addr; mwd = bus.mem_wdata;
        end
        req_cnt++;
        if (req_cnt == ack_after + 1) begin
          bus.mem_ack = 1; bus.mem_rdata = rd;
        end
      end
      @(posedge clk); #1;
      bus.mem_ack = 0; bus.mem_rdata = $urandom;
    end
    if (done_cyc > 0) begin
      @(negedge clk);
      pulse_ok = !done && !busy && !bus.mem_req;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({bus.mem_req, bus.mem_we, busy, done, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b expected 00000",
        {bus.mem_req, bus.mem_we, busy, done, err});
    end
    n_tests++;
    if ({bus.mem_be, bus.mem_addr, bus.mem_wdata, rdata} !== 100'd0) begin
      n_fail++;
      $display("FAIL reset_data: be %h addr %h wd %h rdata %h expected 0",
        bus.mem_be, bus.mem_addr, bus.mem_wdata, rdata);
    end
  endtask

  task automatic test_lw();
    int rc, dc; logic we, de, po; logic [3:0] be; logic [31:0] ma, mw, dr;
    run_access(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1,
      rc, we, be, ma, mw, dc, de, dr, po);
    n_tests++;
    if ({we, be, ma} !== {1'b0, 4'b1111, 32'h100}) begin
      n_fail++;
      $display("FAIL lw_bus: got we %b be %b addr %h expected 0 1111 100", we, be, ma);
    end
    n_tests++;
    if (dc !== 2 || de !== 1'b0 || dr !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL lw_result: got cyc %0d err %b rdata %h expected 2 0 deadbeef", dc, de, dr);
    end
    n_tests++;
    if (po !== 1'b1) begin
      n_fail++;
      $display("FAIL lw_pulse: got %b expected 1", po);
    end
    model_rdata = 32'hDEADBEEF;
  endtask

  task automatic test_lb_lbu();
    int rc, dc; logic we, de, po; logic [3:0] be; logic [31:0] ma, mw, dr;
    run_access(0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1, 0,
      rc, we, be, ma, mw, dc, de, dr, po);
    n_tests++;
    if (dr !== 32'hFFFFFF80 || be !== 4'b1000 || de !== 1'b0) begin
      n_fail++;
      $display("FAIL lb: got rdata %h be %b err %b expected ffffff80 1000 0", dr, be, de);
    end
    run_access(0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 0,
      rc, we, be, ma, mw, dc, de, dr, po);
    n_tests++;
    if (dr !== 32'h00000080 || de !== 1'b0) begin
      n_fail++;
      $display("FAIL lbu: got rdata %h err %b expected 00000080 0", dr, de);
    end
    model_rdata = 32'h00000080;
  endtask

  task automatic test_sh();
    int rc, dc; logic we, de, po; logic [3:0] be; logic [31:0] ma, mw, dr;
    run_access(1, 3'b001, 32'h202, 32'h1234ABCD, 32'h55555555, 0, 0,
      rc, we, be, ma, mw, dc, de, dr, po);
    n_tests++;
    if ({we, be, ma, mw} !== {1'b1, 4'b1100, 32'h200, 32'hABCDABCD}) begin
      n_fail++;
      $display("FAIL sh_bus: got we %b be %b addr %h wd %h expected 1 1100 200 abcdabcd",
        we, be, ma, mw);
    end
    n_tests++;
    if (de !== 1'b0 || dr !== model_rdata) begin
      n_fail++;
      $display("FAIL sh_rdata: got err %b rdata %h expected 0 %h", de, dr, model_rdata);
    end
  endtask

  task automatic test_errors();
    int rc, dc; logic we, de, po; logic [3:0] be; logic [31:0] ma, mw, dr;
    run_access(0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0,
      rc, we, be, ma, mw, dc, de, dr, po);
    n_tests++;
    if (rc !== 0 || dc !== 1 || de !== 1'b1 || dr !== 32'h0) begin
      n_fail++;
      $display("FAIL misaligned: got req %0d cyc %0d err %b rdata %h expected 0 1 1 0",
        rc, dc, de, dr);
    end
    run_access(0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0,
      rc, we, be, ma, mw, dc, de, dr, po);
    n_tests++;
    if (rc !== 0 || dc !== 1 || de !== 1'b1 || po !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_f3: got req %0d cyc %0d err %b pulse %b expected 0 1 1 1",
        rc, dc, de, po);
    end
    model_rdata = 32'h0;
  endtask

  task automatic test_timeout();
    int rc, dc; logic we, de, po; logic [3:0] be; logic [31:0] ma, mw, dr;
    run_access(0, 3'b010, 32'h300, 32'h0, 32'h0, -1, 0,
      rc, we, be, ma, mw, dc, de, dr, po);
    n_tests++;
    if (rc !== 16 || dc !== 17 || de !== 1'b1 || dr !== 32'h0 || po !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout: got req %0d cyc %0d err %b rdata %h expected 16 17 1 0",
        rc, dc, de, dr);
    end
    run_access(0, 3'b010, 32'h300, 32'h0, 32'h12345678, 15, 0,
      rc, we, be, ma, mw, dc, de, dr, po);
    n_tests++;
    if (rc !== 16 || dc !== 17 || de !== 1'b0 || dr !== 32'h12345678) begin
      n_fail++;
      $display("FAIL ack_at_limit: got req %0d cyc %0d err %b rdata %h expected 16 17 0 12345678",
        rc, dc, de, dr);
    end
    model_rdata = 32'h12345678;
  endtask

  task automatic test_reset_mid();
    int rc, dc, ndone; logic we, de, po; logic [3:0] be; logic [31:0] ma, mw, dr;
    @(posedge clk); #1;
    start = 1; is_store = 0; funct3 = 3'b010; addr = 32'h40;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    n_tests++;
    if (bus.mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_req_up: got %b expected 1", bus.mem_req);
    end
    #1 rst_n = 0;
    #1;
    n_tests++;
    if (bus.mem_req !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got req %b busy %b rdata %h expected 0 0 0",
        bus.mem_req, busy, rdata);
    end
    @(posedge clk); #1 rst_n = 1;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 bus.mem_ack = (i == 1);
      if (done) ndone++;
    end
    bus.mem_ack = 0;
    n_tests++;
    if (ndone !== 0) begin
      n_fail++;
      $display("FAIL no_done_after_reset: got %0d expected 0", ndone);
    end
    run_access(0, 3'b001, 32'h46, 32'h0, 32'h7FFF1234, 2, 0,
      rc, we, be, ma, mw, dc, de, dr, po);
    n_tests++;
    if (dr !== 32'h00007FFF || dc !== 4 || de !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_lh: got rdata %h cyc %0d err %b expected 00007fff 4 0",
        dr, dc, de);
    end
    model_rdata = 32'h00007FFF;
  endtask

  task automatic test_random();
    int rc, dc, aa; logic we, de, po; logic [3:0] be; logic [31:0] ma, mw, dr;
    logic st; logic [2:0] f3; logic [31:0] a, wd, rd;
    bit ok; logic [3:0] ebe; logic [31:0] emw, eld;
    for (int i = 0; i < 60; i++) begin
      st = 1'($urandom); f3 = 3'($urandom);
      a = $urandom; wd = $urandom; rd = $urandom;
      aa = $urandom_range(0, 3);
      model(st, f3, a, wd, rd, ok, ebe, emw, eld);
      run_access(st, f3, a, wd, rd, aa, 1'($urandom),
        rc, we, be, ma, mw, dc, de, dr, po);
      if (ok) begin
        if (!st) model_rdata = eld;
        n_tests++;
        if (rc !== aa + 1 || we !== st || be !== ebe ||
            ma !== {a[31:2], 2'b00} || (st && mw !== emw)) begin
          n_fail++;
          $display("FAIL rand_bus[%0d]: got req %0d we %b be %b addr %h wd %h expected %0d %b %b %h %h",
            i, rc, we, be, ma, mw, aa + 1, st, ebe, {a[31:2], 2'b00}, emw);
        end
        n_tests++;
        if (dc !== aa + 2 || de !== 1'b0 || dr !== model_rdata || po !== 1'b1) begin
          n_fail++;
          $display("FAIL rand_done[%0d]: got cyc %0d err %b rdata %h expected %0d 0 %h",
            i, dc, de, dr, aa + 2, model_rdata);
        end
      end else begin
        model_rdata = 32'h0;
        n_tests++;
        if (rc !== 0 || dc !== 1 || de !== 1'b1 || dr !== 32'h0) begin
          n_fail++;
          $display("FAIL rand_err[%0d]: got req %0d cyc %0d err %b rdata %h expected 0 1 1 0",
            i, rc, dc, de, dr);
        end
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; model_rdata = 0;
    rst_n = 0; start = 0; is_store = 0; funct3 = 0;
    addr = 0; wdata = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
